mealy_step_arbiter: RTL and testbench
=====================================

# mealy_step_arbiter

Two-requester round-robin controller for a shared 5-state Mealy step engine: an engine with active-high reset, a DIN1 state-steering input, a DIN2 output-select input and a registered 5-bit Q. The block grants the engine to one requester at a time and resets it to st0 at the start of every grant. It forwards the granted requester's DIN1/DIN2 step stream to the engine and returns each registered Q result, tagged with the requester ID. It sits between the engine instance and its two client blocks.

## Interface
Parameters:
- MAX_STEPS, 8, steps per grant before forced release; legal range 1..255.
- QW, 5, engine result width.
- TIMEOUT, 16, idle cycles before grant revocation; used only with the macro; legal range 1..255.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ0, REQ1  in  1  engine request, held high for the whole session.
- STEP0_VALID, STEP1_VALID  in  1  step present this cycle.
- STEP0_D1, STEP1_D1  in  1  DIN1 value for the step.
- STEP0_D2, STEP1_D2  in  1  DIN2 value for the step.
- GNT0, GNT1  out  1  grant, registered, one-hot or zero.
- ENG_RST  out  1  engine reset, active-high, registered.
- ENG_EN  out  1  engine step strobe, combinational.
- ENG_DIN1, ENG_DIN2  out  1  muxed step inputs, combinational.
- ENG_Q  in  QW  engine registered output.
- RSP_VALID  out  1  result valid, registered.
- RSP_ID  out  1  requester that issued the step.
- RSP_Q  out  QW  captured ENG_Q.
- TMO  out  1  one-cycle pulse on timeout revocation; tied to 0 without the macro.

## Operation
- States: IDLE, ENGRST, RUN, DRAIN.
- IDLE
  - If any REQ is high, select the winner, set its GNT and ENG_RST, then go to ENGRST.
  - Both REQs high: the winner is the requester not served last.
  - Round-robin pointer after reset favours REQ0.
- ENGRST
  - Lasts exactly 1 cycle. ENG_RST=1 and GNT is held.
  - Next state is RUN. ENG_RST clears on entry to RUN.
- RUN
  - A step is accepted when GNTx=1, REQx=1 and STEPx_VALID=1.
  - Accept cycle: ENG_EN=1, ENG_DIN1=STEPx_D1, ENG_DIN2=STEPx_D2. Otherwise all three are 0.
  - Non-granted STEP/REQ inputs are ignored. A losing requester keeps REQ high and waits.
  - Step counter: 8 bits, cleared on grant, incremented per accepted step.
  - Leave to DRAIN when the MAX_STEPS-th step is accepted or REQx=0. GNT clears on DRAIN entry.
- DRAIN
  - Lasts 1 cycle. It absorbs the response to the final step.
  - The pointer toggles to the other requester. Next state is IDLE.
- Responses
  - RSP_VALID=1 exactly one cycle after each accept cycle.
  - RSP_Q = ENG_Q sampled that cycle, i.e. the engine output registered at the accept edge.
  - RSP_ID = index of the grant under which the step was accepted.
  - RSP_VALID is a single-cycle pulse per step. There is no back-pressure.
- Reset
  - RST_N low at any time forces state to IDLE, the pointer to requester 0 and the counter to 0.
  - GNT0=GNT1=0, RSP_VALID=0, RSP_ID=0, RSP_Q=0, TMO=0.
  - ENG_RST=1, which holds the engine in st0 through reset.
  - ENG_RST clears on the first CLK edge after RST_N rises.
  - Reset mid-session drops the grant immediately and discards any pending response.

## Timing
- REQ rise to GNT high: 1 cycle when IDLE. GNT high to first possible accept: 1 cycle (the ENGRST cycle).
- Accept to RSP_VALID: 1 cycle.
- Back-to-back steps are accepted every cycle.
- Minimum GNT-low gap between sessions: 2 cycles (DRAIN, IDLE).
- A REQ drop is seen in the same cycle. No step is accepted in a cycle where REQx=0.

## Configuration
- Macro: MEALY_STEP_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit idle counter runs in RUN. It is cleared on each accept and on grant.
  - When it reaches TIMEOUT with no accept, the grant is revoked and the block enters DRAIN.
  - TMO pulses for 1 cycle, coincident with DRAIN.
  - The pointer advances as on a normal release.
- Not defined: no idle counter. The grant is held until REQ drops or MAX_STEPS steps are accepted. TMO is constant 0.

## Test plan
- Reset, then REQ0=1 only → GNT0 high at edge 1, ENG_RST=1 for exactly 1 cycle, first accept possible at edge 2; 3 steps then REQ0=0 → 3 RSP_VALID pulses, RSP_ID=0, GNT0 low next cycle.
- REQ0=REQ1=1 in IDLE after reset → GNT0 first; after its release GNT1 follows with a 2-cycle gap; then REQ0 and REQ1 both high again → GNT0 (pointer alternates).
- MAX_STEPS=8, continuous STEP0_VALID with D1=1, D2=1 → exactly 8 ENG_EN pulses, GNT0 drops after the 8th, RSP_Q sequence matches the engine (first result 5'h10 from st0, then 5'h17 from st1).
- STEP1_VALID toggling while GNT0 is held → ENG_EN and ENG_DIN1/ENG_DIN2 follow requester 0 only; no RSP with RSP_ID=1.
- RST_N pulled low mid-RUN with a step just accepted → GNT0=0 and ENG_RST=1 asynchronously, no RSP_VALID after reset, next grant goes to requester 0.
- With MEALY_STEP_ARB_TIMEOUT_EN defined and TIMEOUT=16, grant held with no steps for 16 cycles → TMO pulse, GNT low, pending REQ1 granted 2 cycles later; without the macro, the grant persists indefinitely.

Source files
------------

// File: rtl/mealy_step_arbiter.sv
// Round-robin front end that time-shares one 5-state Mealy step engine between two requesters.
// Optional idle-timeout revocation is enabled by defining MEALY_STEP_ARB_TIMEOUT_EN.
module mealy_step_arbiter #(
  parameter int MAX_STEPS = 8,
  parameter int QW        = 5,
  parameter int TIMEOUT   = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          STEP0_VALID,
  input  logic          STEP1_VALID,
  input  logic          STEP0_D1,
  input  logic          STEP1_D1,
  input  logic          STEP0_D2,
  input  logic          STEP1_D2,
  output logic          GNT0,
  output logic          GNT1,
  output logic          ENG_RST,
  output logic          ENG_EN,
  output logic          ENG_DIN1,
  output logic          ENG_DIN2,
  input  logic [QW-1:0] ENG_Q,
  output logic          RSP_VALID,
  output logic          RSP_ID,
  output logic [QW-1:0] RSP_Q,
  output logic          TMO
);

  if (MAX_STEPS < 1 || MAX_STEPS > 255 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
    $error("mealy_step_arbiter: MAX_STEPS and TIMEOUT must lie in 1..255");
  end

  typedef enum logic [1:0] {IDLE, ENGRST, RUN, DRAIN} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_STEPS);

  state_t        state;
  logic          ptr;        // preferred requester when both ask
  logic          owner;      // requester holding the current grant
  logic [1:0]    gnt;
  logic          eng_rst;
  logic [7:0]    step_cnt;
  logic          rsp_valid;
  logic          rsp_id;
  logic [QW-1:0] rsp_q_hold;

`ifdef MEALY_STEP_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT - 1);
  logic [7:0] idle_cnt;
  logic       tmo_q;
`endif

  logic [1:0] req_v;
  logic [1:0] vld_v;
  logic [1:0] d1_v;
  logic [1:0] d2_v;
  logic       req_own;
  logic       accept;
  logic       win;
  logic [7:0] step_nxt;

  assign req_v = {REQ1, REQ0};
  assign vld_v = {STEP1_VALID, STEP0_VALID};
  assign d1_v  = {STEP1_D1, STEP0_D1};
  assign d2_v  = {STEP1_D2, STEP0_D2};

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_own  = req_v[owner];
    accept   = 1'b0;
    ENG_EN   = 1'b0;
    ENG_DIN1 = 1'b0;
    ENG_DIN2 = 1'b0;
    if (state == RUN && req_own && vld_v[owner]) begin
      accept   = 1'b1;
      ENG_EN   = 1'b1;
      ENG_DIN1 = d1_v[owner];
      ENG_DIN2 = d2_v[owner];
    end
    // Both asking: the pointer decides; otherwise whoever asks wins.
    win      = (req_v == 2'b11) ? ptr : req_v[1];
    step_nxt = step_cnt + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      gnt        <= 2'b00;
      eng_rst    <= 1'b1;
      step_cnt   <= 8'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_q_hold <= '0;
`ifdef MEALY_STEP_ARB_TIMEOUT_EN
      idle_cnt   <= 8'd0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      rsp_valid <= accept;
      if (accept)    rsp_id     <= owner;
      if (rsp_valid) rsp_q_hold <= ENG_Q;
`ifdef MEALY_STEP_ARB_TIMEOUT_EN
      tmo_q <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (|req_v) begin
            owner    <= win;
            gnt      <= win ? 2'b10 : 2'b01;
            eng_rst  <= 1'b1;
            step_cnt <= 8'd0;
`ifdef MEALY_STEP_ARB_TIMEOUT_EN
            idle_cnt <= 8'd0;
`endif
            state    <= ENGRST;
          end else begin
            eng_rst  <= 1'b0;
          end
        end

        ENGRST: begin
          eng_rst <= 1'b0;
          state   <= RUN;
        end

        RUN: begin
          if (accept) step_cnt <= step_nxt;
          if ((accept && step_nxt == MAX_CNT) || !req_own) begin
            gnt   <= 2'b00;
            state <= DRAIN;
          end
`ifdef MEALY_STEP_ARB_TIMEOUT_EN
          else if (accept) begin
            idle_cnt <= 8'd0;
          end else if (idle_cnt == TMO_LIMIT) begin
            gnt   <= 2'b00;
            tmo_q <= 1'b1;
            state <= DRAIN;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
`endif
        end

        DRAIN: begin
          // The final step's response leaves this cycle; hand priority to the other side.
          ptr   <= ~owner;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign GNT0      = gnt[0];
  assign GNT1      = gnt[1];
  assign ENG_RST   = eng_rst;
  assign RSP_VALID = rsp_valid;
  assign RSP_ID    = rsp_id;
  // Engine Q registered at the accept edge is live during the response cycle; hold it afterwards.
  assign RSP_Q     = rsp_valid ? ENG_Q : rsp_q_hold;

`ifdef MEALY_STEP_ARB_TIMEOUT_EN
  assign TMO = tmo_q;
`else
  assign TMO = 1'b0;
`endif

endmodule

// File: tb/tb_mealy_step_arbiter.sv
// Directed self-checking bench for mealy_step_arbiter with a simple accumulating engine stand-in.
module tb_mealy_step_arbiter;

  logic       CLK;
  logic       RST_N;
  logic       REQ0, REQ1;
  logic       STEP0_VALID, STEP1_VALID;
  logic       STEP0_D1, STEP1_D1, STEP0_D2, STEP1_D2;
  logic       GNT0, GNT1, ENG_RST, ENG_EN, ENG_DIN1, ENG_DIN2;
  logic [4:0] ENG_Q;
  logic       RSP_VALID, RSP_ID;
  logic [4:0] RSP_Q;
  logic       TMO;

  int tests = 0;
  int fails = 0;

  mealy_step_arbiter #(.MAX_STEPS(8), .QW(5), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .REQ1(REQ1),
    .STEP0_VALID(STEP0_VALID), .STEP1_VALID(STEP1_VALID),
    .STEP0_D1(STEP0_D1), .STEP1_D1(STEP1_D1),
    .STEP0_D2(STEP0_D2), .STEP1_D2(STEP1_D2),
    .GNT0(GNT0), .GNT1(GNT1), .ENG_RST(ENG_RST), .ENG_EN(ENG_EN),
    .ENG_DIN1(ENG_DIN1), .ENG_DIN2(ENG_DIN2), .ENG_Q(ENG_Q),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_Q(RSP_Q), .TMO(TMO)
  );

  // Engine stand-in: sync active-high reset to 0, each step adds {D1,D2,1} (5 bits).
  always_ff @(posedge CLK) begin
    if (ENG_RST)     ENG_Q <= 5'd0;
    else if (ENG_EN) ENG_Q <= ENG_Q + {2'b00, ENG_DIN1, ENG_DIN2, 1'b1};
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQ0 = 0; REQ1 = 0;
    STEP0_VALID = 0; STEP1_VALID = 0;
    STEP0_D1 = 0; STEP1_D1 = 0; STEP0_D2 = 0; STEP1_D2 = 0;
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    // ---- Reset state
    do_reset();
    check("rst_gnt0", GNT0, 0);
    check("rst_gnt1", GNT1, 0);
    check("rst_eng_rst", ENG_RST, 1);
    check("rst_rsp_valid", RSP_VALID, 0);
    check("rst_rsp_id", RSP_ID, 0);
    check("rst_rsp_q", RSP_Q, 0);
    check("rst_tmo", TMO, 0);

    // ---- Single requester, 3 steps then release
    REQ0 = 1;
    tick();                                   // grant edge
    check("t1_gnt0", GNT0, 1);
    check("t1_gnt1", GNT1, 0);
    check("t1_eng_rst_on", ENG_RST, 1);
    STEP0_VALID = 1; STEP0_D1 = 1; STEP0_D2 = 0;
    #1 check("t1_no_en_engrst", ENG_EN, 0);
    tick();                                   // RUN
    check("t1_eng_rst_off", ENG_RST, 0);
    check("t1_en", ENG_EN, 1);
    check("t1_din1", ENG_DIN1, 1);
    check("t1_din2", ENG_DIN2, 0);
    tick();                                   // step 1 accepted: 0+5
    check("t1_rsp1_valid", RSP_VALID, 1);
    check("t1_rsp1_id", RSP_ID, 0);
    check("t1_rsp1_q", RSP_Q, 5);
    STEP0_D1 = 0; STEP0_D2 = 1;
    #1 check("t1_din1_b", ENG_DIN1, 0);
    check("t1_din2_b", ENG_DIN2, 1);
    tick();                                   // step 2: 5+3
    check("t1_rsp2_q", RSP_Q, 8);
    STEP0_D1 = 1; STEP0_D2 = 1;
    tick();                                   // step 3: 8+7
    check("t1_rsp3_valid", RSP_VALID, 1);
    check("t1_rsp3_q", RSP_Q, 15);
    REQ0 = 0; STEP0_VALID = 0;
    #1 check("t1_no_en_req_low", ENG_EN, 0);
    check("t1_gnt0_held", GNT0, 1);
    tick();                                   // DRAIN
    check("t1_gnt0_drop", GNT0, 0);
    check("t1_no_rsp", RSP_VALID, 0);

    // ---- Round robin with both requesting
    do_reset();
    REQ0 = 1; REQ1 = 1;
    tick();
    check("t2_gnt0_first", GNT0, 1);
    check("t2_gnt1_wait", GNT1, 0);
    tick();
    tick();
    REQ0 = 0;
    tick();                                   // DRAIN
    check("t2_gap1_g0", GNT0, 0);
    check("t2_gap1_g1", GNT1, 0);
    tick();                                   // IDLE
    check("t2_gap2_g1", GNT1, 0);
    tick();
    check("t2_gnt1", GNT1, 1);
    check("t2_gnt0_off", GNT0, 0);
    REQ0 = 1;
    tick();
    check("t2_gnt1_kept", GNT1, 1);
    REQ1 = 0;
    tick();                                   // DRAIN
    REQ1 = 1;
    tick();                                   // IDLE
    check("t2_gap_b", GNT0 | GNT1, 0);
    tick();
    check("t2_gnt0_again", GNT0, 1);
    check("t2_gnt1_again", GNT1, 0);

    // ---- MAX_STEPS release with requester 1 toggling its steps
    do_reset();
    REQ0 = 1; REQ1 = 1;
    STEP0_VALID = 1; STEP0_D1 = 1; STEP0_D2 = 1;
    STEP1_D1 = 0; STEP1_D2 = 0;
    tick();
    check("t3_gnt0", GNT0, 1);
    tick();                                   // RUN
    for (int k = 1; k <= 8; k++) begin
      STEP1_VALID = k[0];
      #1 check("t3_en", ENG_EN, 1);
      check("t3_din1", ENG_DIN1, 1);
      check("t3_din2", ENG_DIN2, 1);
      tick();
      check("t3_rsp_valid", RSP_VALID, 1);
      check("t3_rsp_id", RSP_ID, 0);
      check("t3_rsp_q", RSP_Q, (7 * k) % 32);
      check("t3_gnt0", GNT0, (k < 8) ? 1 : 0);
    end
    #1 check("t3_no_en_drain", ENG_EN, 0);
    tick();                                   // IDLE
    check("t3_rsp_end", RSP_VALID, 0);
    check("t3_gap_g1", GNT1, 0);
    tick();
    check("t3_gnt1_next", GNT1, 1);
    check("t3_eng_rst", ENG_RST, 1);

    // ---- Reset in the middle of a requester-1 session
    STEP1_VALID = 1; STEP1_D1 = 0; STEP1_D2 = 1;
    tick();                                   // RUN
    #1 check("t5_en", ENG_EN, 1);
    check("t5_din1", ENG_DIN1, 0);
    check("t5_din2", ENG_DIN2, 1);
    tick();                                   // accepted: 0+3
    check("t5_rsp_valid", RSP_VALID, 1);
    check("t5_rsp_id", RSP_ID, 1);
    check("t5_rsp_q", RSP_Q, 3);
    RST_N = 0;
    #1 check("t5_gnt1_async", GNT1, 0);
    check("t5_eng_rst_async", ENG_RST, 1);
    check("t5_rsp_drop", RSP_VALID, 0);
    check("t5_rsp_q_clr", RSP_Q, 0);
    check("t5_en_off", ENG_EN, 0);
    tick();
    check("t5_rsp_in_rst", RSP_VALID, 0);
    RST_N = 1; STEP0_VALID = 0; STEP1_VALID = 0;
    tick();
    check("t5_gnt0_after_rst", GNT0, 1);
    check("t5_gnt1_after_rst", GNT1, 0);
    check("t5_rsp_after_rst", RSP_VALID, 0);

    // ---- Idle grant: timeout revocation or indefinite hold
    tick();                                   // RUN
`ifdef MEALY_STEP_ARB_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("t6_gnt0_hold", GNT0, 1);
      check("t6_tmo_low", TMO, 0);
    end
    tick();
    check("t6_tmo_pulse", TMO, 1);
    check("t6_gnt0_revoked", GNT0, 0);
    tick();
    check("t6_tmo_end", TMO, 0);
    check("t6_gap", GNT0 | GNT1, 0);
    tick();
    check("t6_gnt1", GNT1, 1);
`else
    for (int i = 1; i <= 30; i++) begin
      tick();
      check("t6_gnt0_persist", GNT0, 1);
      check("t6_tmo_zero", TMO, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
